decode: RTL and testbench

Decode stage: consumes 16-bit instruction words pulsed out by the fetch stage, assembles one- or two-word instructions into decoded micro-ops, and buffers them in a small queue toward execute with a valid/ready handshake. Fetch has no backpressure, so overflow is detected and flagged rather than stalled. Sits between fetch and execute; flush from execute discards all in-flight decode state.

---
 rtl/leg_pkg.sv | 29 ++
 rtl/uop_queue.sv | 54 +++++
 rtl/decode.sv | 118 +++++++++++
 tb/tb_decode.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/leg_pkg.sv
// Shared decode types: opcode encoding, decoded micro-op layout and opcode classification.
package leg_pkg;

  localparam int IMM_W = 12;

  typedef enum logic [3:0] {
    OP_NOP       = 4'h0,
    OP_ALU_FIRST = 4'h1,
    OP_ALU_LAST  = 4'hB,
    OP_LDI       = 4'hC,
    OP_JMP       = 4'hD,
    OP_BRZ       = 4'hE,
    OP_HALT      = 4'hF
  } opcode_e;

  typedef struct packed {
    logic [3:0]       opcode;
    logic [3:0]       rd;
    logic [3:0]       rs;
    logic [3:0]       rt;
    logic [IMM_W-1:0] imm;
    logic             has_imm;
  } uop_t;

  function automatic logic is_two_word(input logic [3:0] opcode);
    return (opcode == OP_LDI) || (opcode == OP_JMP) || (opcode == OP_BRZ);
  endfunction

endpackage

// File: rtl/uop_queue.sv
// Small synchronous FIFO with flush; the head entry is presented from storage, zeroed when empty.
module uop_queue #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign pop_ok  = pop && !empty && !flush;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && !flush && (!full || pop_ok);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/decode.sv
// Decode stage: assembles one/two-word instructions into micro-ops and queues them toward execute.
module decode
  import leg_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int INST_WIDTH  = 16,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_inst_ready,
  input  logic [INST_WIDTH-1:0]        i_inst,
  input  logic                         i_flush,
  output logic                         o_uop_valid,
  input  logic                         i_uop_ready,
  output uop_t                         o_uop,
  output logic [$clog2(QUEUE_DEPTH):0] o_count,
  output logic                         o_overflow,
  output logic                         o_halted
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXT    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] lat_op;
  logic [3:0] lat_rd;
  logic [3:0] lat_rs;
  logic [3:0] lat_rt;
  logic       latch_en;
  logic       push_req;
  uop_t       push_uop;
  logic       q_full;
  logic       q_empty;
  logic [3:0] op;

  assign op = i_inst[15:12];

  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    push_uop  = '0;
    latch_en  = 1'b0;
    if (i_inst_ready) begin
      case (state)
        ST_IDLE: begin
          if (op == OP_NOP) begin
            state_nxt = ST_IDLE;
          end else if (is_two_word(op)) begin
            latch_en  = 1'b1;
            state_nxt = ST_EXT;
          end else begin
            push_req        = 1'b1;
            push_uop.opcode = op;
            push_uop.rd     = i_inst[11:8];
            push_uop.rs     = i_inst[7:4];
            push_uop.rt     = i_inst[3:0];
            if (op == OP_HALT) state_nxt = ST_HALTED;
          end
        end
        ST_EXT: begin
          // Extension word is taken verbatim as the immediate; its upper bits are not decoded.
          push_req         = 1'b1;
          push_uop.opcode  = lat_op;
          push_uop.rd      = lat_rd;
          push_uop.rs      = lat_rs;
          push_uop.rt      = lat_rt;
          push_uop.imm     = IMM_W'(i_inst[ADDR_WIDTH-1:0]);
          push_uop.has_imm = 1'b1;
          state_nxt        = ST_IDLE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      o_overflow <= 1'b0;
    end else begin
      state <= i_flush ? ST_IDLE : state_nxt;
      // Full with no pop this cycle means the finished micro-op has nowhere to go.
      if (push_req && q_full && !i_uop_ready && !i_flush) o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (latch_en) begin
      lat_op <= op;
      lat_rd <= i_inst[11:8];
      lat_rs <= i_inst[7:4];
      lat_rt <= i_inst[3:0];
    end
  end

  uop_queue #(
    .WIDTH($bits(uop_t)),
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push_req),
    .wdata (push_uop),
    .pop   (i_uop_ready),
    .flush (i_flush),
    .rdata (o_uop),
    .count (o_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign o_uop_valid = !q_empty;
  assign o_halted    = (state == ST_HALTED);

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: hand-computed expectations checked with immediate assertions.
module tb_decode;
  import leg_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_inst_ready = 1'b0;
  logic [15:0] i_inst = '0;
  logic        i_flush = 1'b0;
  logic        o_uop_valid;
  logic        i_uop_ready = 1'b0;
  uop_t        o_uop;
  logic [1:0]  o_count;
  logic        o_overflow;
  logic        o_halted;

  int checks = 0;
  int errors = 0;

  decode #(.ADDR_WIDTH(12), .INST_WIDTH(16), .QUEUE_DEPTH(2)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_inst_ready (i_inst_ready),
    .i_inst       (i_inst),
    .i_flush      (i_flush),
    .o_uop_valid  (o_uop_valid),
    .i_uop_ready  (i_uop_ready),
    .o_uop        (o_uop),
    .o_count      (o_count),
    .o_overflow   (o_overflow),
    .o_halted     (o_halted)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse(input logic [15:0] w);
    i_inst_ready = 1'b1;
    i_inst       = w;
    tick();
    i_inst_ready = 1'b0;
    i_inst       = '0;
  endtask

  task automatic do_flush();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_valid", 32'(o_uop_valid), 0);
    chk("rst_uop", 32'(o_uop), 0);
    chk("rst_count", 32'(o_count), 0);
    chk("rst_ovf", 32'(o_overflow), 0);
    chk("rst_halt", 32'(o_halted), 0);
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();

    // Single-word op, popped on the following edge
    i_uop_ready = 1'b1;
    pulse(16'h1234);
    chk("sw_valid", 32'(o_uop_valid), 1);
    chk("sw_op", 32'(o_uop.opcode), 1);
    chk("sw_rd", 32'(o_uop.rd), 2);
    chk("sw_rs", 32'(o_uop.rs), 3);
    chk("sw_rt", 32'(o_uop.rt), 4);
    chk("sw_imm", 32'(o_uop.imm), 0);
    chk("sw_has", 32'(o_uop.has_imm), 0);
    chk("sw_cnt", 32'(o_count), 1);
    tick();
    chk("sw_pop_cnt", 32'(o_count), 0);
    chk("sw_pop_valid", 32'(o_uop_valid), 0);

    // Two-word LDI
    pulse(16'hC500);
    chk("tw_first_valid", 32'(o_uop_valid), 0);
    pulse(16'hFABC);
    chk("tw_valid", 32'(o_uop_valid), 1);
    chk("tw_op", 32'(o_uop.opcode), 32'hC);
    chk("tw_rd", 32'(o_uop.rd), 5);
    chk("tw_imm", 32'(o_uop.imm), 32'hABC);
    chk("tw_has", 32'(o_uop.has_imm), 1);
    chk("tw_halt", 32'(o_halted), 0);
    tick();
    chk("tw_pop_valid", 32'(o_uop_valid), 0);

    // Overflow on a full queue
    i_uop_ready = 1'b0;
    pulse(16'h1000);
    chk("of_cnt1", 32'(o_count), 1);
    pulse(16'h2000);
    chk("of_cnt2", 32'(o_count), 2);
    chk("of_ovf_before", 32'(o_overflow), 0);
    pulse(16'h3000);
    chk("of_cnt3", 32'(o_count), 2);
    chk("of_ovf", 32'(o_overflow), 1);
    chk("of_head", 32'(o_uop.opcode), 1);

    // Full queue with simultaneous pop accepts the push
    i_uop_ready = 1'b1;
    pulse(16'h4000);
    chk("fp_cnt", 32'(o_count), 2);
    chk("fp_head2", 32'(o_uop.opcode), 2);
    tick();
    chk("fp_head4", 32'(o_uop.opcode), 4);
    chk("fp_cnt1", 32'(o_count), 1);
    tick();
    chk("fp_cnt0", 32'(o_count), 0);

    // Flush discards a partial two-word instruction
    pulse(16'hD100);
    chk("fl_partial_valid", 32'(o_uop_valid), 0);
    do_flush();
    chk("fl_cnt", 32'(o_count), 0);
    pulse(16'h5000);
    chk("fl_next_valid", 32'(o_uop_valid), 1);
    chk("fl_next_op", 32'(o_uop.opcode), 5);
    chk("fl_next_has", 32'(o_uop.has_imm), 0);
    tick();

    // Flush empties a full queue and keeps overflow sticky
    i_uop_ready = 1'b0;
    pulse(16'h6000);
    pulse(16'h7000);
    chk("fq_cnt", 32'(o_count), 2);
    do_flush();
    chk("fq_cnt0", 32'(o_count), 0);
    chk("fq_valid", 32'(o_uop_valid), 0);
    chk("fq_ovf_sticky", 32'(o_overflow), 1);

    // NOP, HALT, ignored words, flush out of HALTED
    pulse(16'h0000);
    chk("nop_cnt", 32'(o_count), 0);
    pulse(16'hF000);
    chk("halt_flag", 32'(o_halted), 1);
    chk("halt_cnt", 32'(o_count), 1);
    chk("halt_op", 32'(o_uop.opcode), 32'hF);
    pulse(16'h1111);
    chk("halt_ign_cnt", 32'(o_count), 1);
    chk("halt_ign_op", 32'(o_uop.opcode), 32'hF);
    do_flush();
    chk("halt_fl_flag", 32'(o_halted), 0);
    chk("halt_fl_cnt", 32'(o_count), 0);
    pulse(16'hF000);
    chk("halt2_flag", 32'(o_halted), 1);

    // Asynchronous reset mid-cycle
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(o_uop_valid), 0);
    chk("ar_uop", 32'(o_uop), 0);
    chk("ar_cnt", 32'(o_count), 0);
    chk("ar_ovf", 32'(o_overflow), 0);
    chk("ar_halt", 32'(o_halted), 0);
    tick();
    i_rst_n = 1'b1;
    i_uop_ready = 1'b1;
    pulse(16'h2345);
    chk("post_rst_op", 32'(o_uop.opcode), 2);
    chk("post_rst_rt", 32'(o_uop.rt), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
